// File: rtl/mips_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_rf_pkg
//  Description : Register-file constants and the round-robin pick function
//                shared by the register file, decode and the write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_rf_pkg;

   localparam int RF_ADDR_W = 5;
   localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 5'd0;

   // The pick function is sized for the largest legal requester count.
   localparam int RR_MAX_REQ = 4;
   localparam int RR_IDX_W   = 2;

   typedef struct packed {
      logic                any;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // Returns the first valid index at or after ptr, wrapping modulo nreq.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                        input logic [RR_IDX_W-1:0]   ptr,
                                        input int                    nreq);
      rr_pick_t res;
      int       k;
      res = '0;
      for (int i = 0; i < RR_MAX_REQ; i++) begin
         k = int'(ptr) + i;
         if (k >= nreq) k = k - nreq;
         if ((i < nreq) && !res.any && valid[k[RR_IDX_W-1:0]]) begin
            res.any = 1'b1;
            res.idx = k[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin winner selection with its priority pointer;
//                the pointer moves past the winner when advance is strobed.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import mips_rf_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NREQ-1:0]     i_valid,
   input  logic                i_advance,
   output logic [NREQ-1:0]     o_grant,
   output logic [RR_IDX_W-1:0] o_winner,
   output logic                o_any
);

   localparam int PTR_W = $clog2(NREQ);

   logic [PTR_W-1:0]      r_rr_ptr;
   logic [RR_MAX_REQ-1:0] w_valid_pad;
   logic [RR_IDX_W-1:0]   w_ptr_pad;
   logic [RR_IDX_W-1:0]   w_win_inc;
   rr_pick_t              w_pick;

   always_comb begin
      w_valid_pad             = '0;
      w_valid_pad[NREQ-1:0]   = i_valid;
      w_ptr_pad               = '0;
      w_ptr_pad[PTR_W-1:0]    = r_rr_ptr;
   end

   assign w_pick   = rr_pick(w_valid_pad, w_ptr_pad, NREQ);
   assign o_any    = w_pick.any;
   assign o_winner = w_pick.idx;

   generate
      for (genvar k = 0; k < NREQ; k++) begin : g_grant
         assign o_grant[k] = w_pick.any & (w_pick.idx == RR_IDX_W'(k));
      end
   endgenerate

   assign w_win_inc = (int'(w_pick.idx) == NREQ - 1) ? '0
                                                     : w_pick.idx + RR_IDX_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr <= '0;
      end else if (i_advance && w_pick.any) begin
         r_rr_ptr <= w_win_inc[PTR_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Round-robin sharing of the register-file write port with a
//                one-entry staging register that holds across i_rf_hold.
//                Optional staged-write forwarding: define RF_WR_FWD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
   import mips_rf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NREQ-1:0]           i_req_valid,
   input  logic [RF_ADDR_W*NREQ-1:0] i_req_addr,
   input  logic [WIDTH*NREQ-1:0]     i_req_data,
   output logic [NREQ-1:0]           o_req_ready,
   input  logic                      i_rf_hold,
   output logic                      o_rf_we,
   output logic [RF_ADDR_W-1:0]      o_rf_addr,
   output logic [WIDTH-1:0]          o_rf_data
`ifdef RF_WR_FWD_EN
   ,
   input  logic [RF_ADDR_W-1:0]      i_rd_addr1,
   input  logic [RF_ADDR_W-1:0]      i_rd_addr2,
   output logic                      o_fwd_hit1,
   output logic                      o_fwd_hit2,
   output logic [WIDTH-1:0]          o_fwd_data1,
   output logic [WIDTH-1:0]          o_fwd_data2
`endif
);

   logic                 r_stage_valid;
   logic [RF_ADDR_W-1:0] r_stage_addr;
   logic [WIDTH-1:0]     r_stage_data;

   logic                 w_can_accept;
   logic                 w_xfer;
   logic                 w_any;
   logic [NREQ-1:0]      w_grant;
   logic [RR_IDX_W-1:0]  w_winner;
   logic [RF_ADDR_W-1:0] w_sel_addr;
   logic [WIDTH-1:0]     w_sel_data;

   // A full stage can still be replaced in the cycle it drains to the RF.
   assign w_can_accept = ~r_stage_valid | ~i_rf_hold;
   assign w_xfer       = w_any & w_can_accept;
   assign o_req_ready  = w_grant & {NREQ{w_can_accept}};

   rr_arbiter #(
      .NREQ      (NREQ)
   ) u_rr_arbiter (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_valid   (i_req_valid),
      .i_advance (w_xfer),
      .o_grant   (w_grant),
      .o_winner  (w_winner),
      .o_any     (w_any)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (int'(w_winner) == k) begin
            w_sel_addr = i_req_addr[RF_ADDR_W*k +: RF_ADDR_W];
            w_sel_data = i_req_data[WIDTH*k +: WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage_valid <= 1'b0;
         r_stage_addr  <= '0;
         r_stage_data  <= '0;
      end else if (w_xfer) begin
         r_stage_valid <= 1'b1;
         r_stage_addr  <= w_sel_addr;
         r_stage_data  <= w_sel_data;
      end else if (!i_rf_hold) begin
         r_stage_valid <= 1'b0;
      end
   end

   // Writes to r0 complete the handshake but never reach the RF.
   assign o_rf_we   = r_stage_valid & ~i_rf_hold & (r_stage_addr != RF_ZERO_ADDR);
   assign o_rf_addr = r_stage_addr;
   assign o_rf_data = r_stage_data;

`ifdef RF_WR_FWD_EN
   assign o_fwd_hit1  = r_stage_valid & (r_stage_addr == i_rd_addr1) &
                        (i_rd_addr1 != RF_ZERO_ADDR);
   assign o_fwd_hit2  = r_stage_valid & (r_stage_addr == i_rd_addr2) &
                        (i_rd_addr2 != RF_ZERO_ADDR);
   assign o_fwd_data1 = r_stage_data;
   assign o_fwd_data2 = r_stage_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// Bench for rf_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared against a queue-free behavioural model.
module tb_rf_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        rf_hold;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
`ifdef RF_WR_FWD_EN
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state
   int        m_ptr;
   bit        m_sv;
   bit [4:0]  m_sa;
   bit [31:0] m_sd;

   // DUT values sampled by the most recent step
   logic [2:0]  s_ready;
   logic        s_we;
   logic [4:0]  s_addr;
   logic [31:0] s_data;

   rf_write_arbiter #(.WIDTH(32), .NREQ(3)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_addr  (req_addr),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .i_rf_hold   (rf_hold),
      .o_rf_we     (rf_we),
      .o_rf_addr   (rf_addr),
      .o_rf_data   (rf_data)
`ifdef RF_WR_FWD_EN
      ,
      .i_rd_addr1  (rd_addr1),
      .i_rd_addr2  (rd_addr2),
      .o_fwd_hit1  (fwd_hit1),
      .o_fwd_hit2  (fwd_hit2),
      .o_fwd_data1 (fwd_data1),
      .o_fwd_data2 (fwd_data2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_sv  = 1'b0;
      m_sa  = '0;
      m_sd  = '0;
   endtask

   // Called at a falling edge: drive inputs, compare, advance model, move on.
   task automatic step(input logic [2:0] v, input logic [14:0] a,
                       input logic [95:0] d, input logic h);
      int         w;
      bit         can;
      logic [2:0] exp_ready;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      rf_hold   = h;
      #1;
      w = -1;
      for (int i = 0; i < 3; i++) begin
         if (w < 0 && v[(m_ptr + i) % 3]) w = (m_ptr + i) % 3;
      end
      can       = !m_sv || !h;
      exp_ready = (w >= 0 && can) ? 3'(1 << w) : 3'b000;
      s_ready = req_ready;
      s_we    = rf_we;
      s_addr  = rf_addr;
      s_data  = rf_data;
      chk("ready",   64'(req_ready), 64'(exp_ready));
      chk("rf_we",   64'(rf_we),     64'(m_sv && !h && m_sa != 0));
      chk("rf_addr", 64'(rf_addr),   64'(m_sa));
      chk("rf_data", 64'(rf_data),   64'(m_sd));
`ifdef RF_WR_FWD_EN
      chk("fwd_hit1",  64'(fwd_hit1),  64'(m_sv && m_sa == rd_addr1 && rd_addr1 != 0));
      chk("fwd_hit2",  64'(fwd_hit2),  64'(m_sv && m_sa == rd_addr2 && rd_addr2 != 0));
      chk("fwd_data1", 64'(fwd_data1), 64'(m_sd));
      chk("fwd_data2", 64'(fwd_data2), 64'(m_sd));
`endif
      if (w >= 0 && can) begin
         m_sv  = 1'b1;
         m_sa  = a[5*w +: 5];
         m_sd  = d[32*w +: 32];
         m_ptr = (w + 1) % 3;
      end else if (!h) begin
         m_sv = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [14:0] a;
      logic [95:0] d;
      rst_n     = 1'b0;
      req_valid = 3'b111;
      req_addr  = '0;
      req_data  = '0;
      rf_hold   = 1'b0;
      rd_addr1  = '0;
      rd_addr2  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_we",    64'(rf_we),     64'd0);
      chk("reset_addr",  64'(rf_addr),   64'd0);
      chk("reset_data",  64'(rf_data),   64'd0);
      chk("reset_ready", 64'(req_ready), 64'b001);
      rst_n = 1'b1;

      // all three valid for six cycles: grants rotate 0,1,2,0,1,2
      a = {5'd3, 5'd2, 5'd1};
      d = {32'hA2, 32'hA1, 32'hA0};
      for (int i = 0; i < 6; i++) begin
         step(3'b111, a, d, 1'b0);
         chk("rr_ready", 64'(s_ready), 64'(1 << (i % 3)));
         if (i > 0) begin
            chk("rr_we",   64'(s_we),   64'd1);
            chk("rr_addr", 64'(s_addr), 64'((i - 1) % 3 + 1));
            chk("rr_data", 64'(s_data), 64'(32'hA0 + (i - 1) % 3));
         end
      end
      step(3'b000, a, d, 1'b0);
      chk("rr_last_addr", 64'(s_addr), 64'd3);
      chk("rr_last_data", 64'(s_data), 64'hA2);

      // write to r0 is accepted and dropped
      step(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'hDEAD, 32'd0}, 1'b0);
      chk("r0_ready", 64'(s_ready), 64'b010);
      step(3'b000, '0, '0, 1'b0);
      chk("r0_we",   64'(s_we),   64'd0);
      chk("r0_data", 64'(s_data), 64'hDEAD);

      // stage r5=0x1234, hold three cycles with requester 2 waiting
      a = {5'd6, 5'd0, 5'd5};
      d = {32'h5678, 32'h0, 32'h1234};
      step(3'b001, a, d, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(3'b100, a, d, 1'b1);
         chk("hold_ready", 64'(s_ready), 64'd0);
         chk("hold_we",    64'(s_we),    64'd0);
      end
      step(3'b100, a, d, 1'b0);
      chk("rel_we",    64'(s_we),    64'd1);
      chk("rel_addr",  64'(s_addr),  64'd5);
      chk("rel_data",  64'(s_data),  64'h1234);
      chk("rel_ready", 64'(s_ready), 64'b100);
      step(3'b000, a, d, 1'b0);
      chk("b2b_addr", 64'(s_addr), 64'd6);

      // same destination from requesters 0 and 2, pointer at 0
      a = {5'd7, 5'd0, 5'd7};
      d = {32'h22, 32'h0, 32'h11};
      step(3'b101, a, d, 1'b0);
      chk("same_first", 64'(s_ready), 64'b001);
      step(3'b100, a, d, 1'b0);
      chk("same_w1", 64'(s_data), 64'h11);
      chk("same_r2", 64'(s_ready), 64'b100);
      step(3'b000, a, d, 1'b0);
      chk("same_w2", 64'(s_data), 64'h22);

      // hold while empty: one transfer accepted, next one waits
      a = {5'd9, 5'd8, 5'd9};
      d = {32'h0, 32'h77, 32'hBEEF};
      step(3'b001, a, d, 1'b1);
      chk("hempty_acc", 64'(s_ready), 64'b001);
      rd_addr1 = 5'd9;
      rd_addr2 = 5'd0;
      step(3'b010, a, d, 1'b1);
      chk("hempty_wait", 64'(s_ready), 64'd0);
`ifdef RF_WR_FWD_EN
      chk("fwd_lit_hit1", 64'(fwd_hit1),  64'd1);
      chk("fwd_lit_dat1", 64'(fwd_data1), 64'hBEEF);
      chk("fwd_lit_hit2", 64'(fwd_hit2),  64'd0);
`endif

      // reset in the middle of a hold drops the staged write
      rst_n = 1'b0;
      #1;
      chk("rst_hold_we", 64'(rf_we), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(3'b000, a, d, 1'b0);
      chk("rst_drop_we", 64'(s_we), 64'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 3; k++) begin
            a[5*k +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d[32*k +: 32] = $urandom;
         end
         rd_addr1 = ($urandom_range(0, 1) == 1) ? m_sa : 5'($urandom);
         rd_addr2 = 5'($urandom);
         step(3'($urandom), a, d, ($urandom_range(0, 2) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the 32×WIDTH MIPS register file between NREQ writeback sources, such as the ALU writeback, the load unit and the debug/monitor port. Grants one source per cycle with a round-robin policy and uses a valid/ready handshake per source. The granted write is staged in a one-entry output register that drives the register file's write-enable, address and data. The block sits between the pipeline writeback sources and the register file, and holds the staged write while the register file is frozen.

## Interface
- WIDTH, 32, data width; must match the register file.
- NREQ, 3, number of requesters; legal range 2..4.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NREQ  requester k has a write pending.
- i_req_addr  in  5*NREQ  destination register; slice k = [5k+4:5k].
- i_req_data  in  WIDTH*NREQ  write data; slice k = [WIDTH*k+WIDTH-1:WIDTH*k].
- o_req_ready  out  NREQ  one-hot or zero; transfer on valid&ready at the clock edge.
- i_rf_hold  in  1  register file frozen; staged write must not be issued.
- o_rf_we  out  1  to the register file's write enable.
- o_rf_addr  out  5  to the register file's write address.
- o_rf_data  out  WIDTH  to the register file's write data.
- i_rd_addr1, i_rd_addr2  in  5 each  read addresses presented to the register file (RF_WR_FWD_EN only).
- o_fwd_hit1, o_fwd_hit2  out  1 each  staged write targets the read address (RF_WR_FWD_EN only).
- o_fwd_data1, o_fwd_data2  out  WIDTH each  staged data (RF_WR_FWD_EN only).

## Operation
- State:
  - stage_valid, stage_addr[4:0] and stage_data[WIDTH-1:0].
  - rr_ptr[$clog2(NREQ)-1:0], which is the highest-priority index.
- can_accept = ~stage_valid | ~i_rf_hold.
- Grant: search from rr_ptr upward, wrapping modulo NREQ, for the first k with i_req_valid[k].
  - o_req_ready[k] = can_accept & (k is the winner).
  - All other o_req_ready bits are 0.
- On a transfer of k:
  - stage <= {1, addr_k, data_k}.
  - rr_ptr <= (k+1) mod NREQ.
- No transfer and ~i_rf_hold: stage_valid <= 0.
- No transfer and i_rf_hold: the stage holds all fields.
- rr_ptr changes only on a transfer.
- o_rf_we = stage_valid & ~i_rf_hold & (stage_addr != 0).
- o_rf_addr = stage_addr and o_rf_data = stage_data at all times.
- Address-0 writes are accepted normally (handshake completes, stage loads), but o_rf_we stays 0, so the write is dropped.
- Same-address requests from two sources in one cycle: the one earlier in round-robin order is written first, and the other follows in a later cycle. The last-granted value wins.
- Readiness is combinational from i_req_valid, rr_ptr, stage_valid and i_rf_hold. There is no dependency on i_req_addr or i_req_data.

## Timing
- Reset values: stage_valid=0, stage_addr=0, stage_data=0, rr_ptr=0.
  - Therefore o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_req_ready follows inputs, and o_fwd_hit*=0.
- Transfer at edge N: o_rf_we=1 during cycle N+1 if not held. The register file captures at edge N+1, and the value is readable from cycle N+2.
- Throughput is one write per cycle with i_rf_hold=0.
- A held stage issues in the first cycle with i_rf_hold=0. In that same cycle a new transfer may load the stage (back-to-back, no bubble).
- Reset mid-hold: the staged write is discarded and never reaches the register file.
- i_rf_hold while the stage is empty: one transfer is still accepted. The next transfer waits until the hold drops.

## Configuration
- RF_WR_FWD_EN defined:
  - o_fwd_hitX = stage_valid & (stage_addr == i_rd_addrX) & (i_rd_addrX != 0).
  - o_fwd_dataX = stage_data.
  - This covers the one-cycle window, and any hold period, before the staged write lands.
- RF_WR_FWD_EN undefined: the fwd and rd_addr ports are absent and there is no compare logic.

## Structure
- Shared package mips_rf_pkg holds the following, shared with the register file and decode:
  - RF_ADDR_W=5 and RF_ZERO_ADDR=5'd0.
  - The function rr_pick(valid, ptr), which returns the winner index and an any-valid flag.
- One sub-module, rr_arbiter (parameter NREQ): combinational winner selection plus the rr_ptr register, with an advance strobe. rf_write_arbiter adds staging, hold and forwarding.

## Test plan
- Reset: i_rst_n=0 with all valids=1 → o_rf_we=0 and o_rf_addr=0. After release, the first grant goes to requester 0.
- All three valid for 6 cycles with addr k+1 and data 0xA0+k → grants 0,1,2,0,1,2. o_rf_we=1 in each following cycle with matching addr and data.
- Requester 1 writes r0 with data 0xDEAD → ready=1 and the stage loads, but o_rf_we stays 0 and a register file read of r0 returns 0.
- i_rf_hold=1 for 3 cycles while the stage holds r5=0x1234 and requester 2 stays valid → o_rf_we=0 and ready=0 throughout. On hold release, o_rf_we=1 with r5=0x1234, and requester 2 is granted in the same cycle.
- Requesters 0 and 2 both write r7 (0x11, 0x22) in one cycle from rr_ptr=0 → r7 reads 0x11, then 0x22. Final value 0x22.
- RF_WR_FWD_EN with the stage holding r9=0xBEEF and i_rd_addr1=9, i_rd_addr2=0 → o_fwd_hit1=1 with data 0xBEEF, and o_fwd_hit2=0.
